// File: rtl/result_collector.sv
// result_collector: frame-tracking write FIFO sink with request/valid read port; optional running XOR checksum under RESULT_COLLECTOR_CHECKSUM_EN
module result_collector #(
  parameter int DATA_W = 21,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              done,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              frame_done,
  output logic              overflow,
  output logic [DATA_W-1:0] checksum
);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc, open;
  assign empty  = count == '0;
  assign full   = count == (ADDR_W+1)'(DEPTH);
  assign rd_acc = rd_req & !empty;
  assign wr_acc = (state == COLLECT) & wr_req & (!full | rd_acc);
  assign open   = (state == IDLE) & start;
  // frame FSM next state; frame_done fires while draining once the FIFO is empty
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    if (state == IDLE && start) state_nxt = COLLECT;
    if (state == COLLECT && done) state_nxt = DRAIN;
    if (state == DRAIN && empty) begin
      state_nxt  = IDLE;
      frame_done = 1'b1;
    end
  end
  // frame state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= wr_data;
  // pointers, occupancy and registered read port
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= rd_acc;
      count <= (wr_acc && !rd_acc) ? count + (ADDR_W+1)'(1) :
               (rd_acc && !wr_acc) ? count - (ADDR_W+1)'(1) : count;
    end
  // per-frame word counter (saturating) and sticky drop flag
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else if (open) begin
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_acc && !(&frame_cnt)) frame_cnt <= frame_cnt + CNT_W'(1);
      if (state == COLLECT && wr_req && !wr_acc) overflow <= 1'b1;
    end
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
  // running XOR of accepted words, cleared when a frame opens
  always_ff @(posedge clk or negedge rst)
    if (!rst) checksum <= '0;
    else if (open) checksum <= '0;
    else if (wr_acc) checksum <= checksum ^ wr_data;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: table-driven and directed checks of result_collector
module tb_result_collector;
  logic clk = 1'b0, rst, start, done, wr_req, rd_req;
  logic [20:0] wr_data, rd_data, checksum;
  logic rd_valid, empty, full, frame_done, overflow;
  logic [4:0] count;
  logic [7:0] frame_cnt;
  int n_chk = 0, n_fail = 0;
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  result_collector dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .wr_req(wr_req),
    .wr_data(wr_data), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .count(count), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .overflow(overflow), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, dn, wr;
    logic [20:0] wd;
    logic rd, rv;
    logic [20:0] rdat;
    logic [4:0] cnt;
    logic emp, ful;
    logic [7:0] fc;
    logic fd, ov;
    logic [20:0] ck;
  } vec_t;

  function automatic vec_t mk(input logic st, dn, wr, input logic [20:0] wd, input logic rd, rv,
                              input logic [20:0] rdat, input logic [4:0] cnt, input logic emp, ful,
                              input logic [7:0] fc, input logic fd, ov, input logic [20:0] ck);
    vec_t v;
    v.st = st; v.dn = dn; v.wr = wr; v.wd = wd; v.rd = rd; v.rv = rv; v.rdat = rdat;
    v.cnt = cnt; v.emp = emp; v.ful = ful; v.fc = fc; v.fd = fd; v.ov = ov; v.ck = ck;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, d, w, input logic [20:0] wd, input logic r);
    start = s; done = d; wr_req = w; wr_data = wd; rd_req = r;
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " count"}, 32'(count), 0);
    chk({tag, " empty"}, 32'(empty), 1);
    chk({tag, " full"}, 32'(full), 0);
    chk({tag, " rd_valid"}, 32'(rd_valid), 0);
    chk({tag, " rd_data"}, 32'(rd_data), 0);
    chk({tag, " frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, " frame_done"}, 32'(frame_done), 0);
    chk({tag, " overflow"}, 32'(overflow), 0);
    chk({tag, " checksum"}, 32'(checksum), 0);
  endtask

  vec_t tbl [14];

  initial begin
    tbl[0]  = mk(1,0,0,0,0, 0,0,0,1,0,0,0,0,0);
    tbl[1]  = mk(0,0,1,1,0, 0,0,1,0,0,1,0,0,1);
    tbl[2]  = mk(0,0,1,2,0, 0,0,2,0,0,2,0,0,3);
    tbl[3]  = mk(0,0,1,3,0, 0,0,3,0,0,3,0,0,0);
    tbl[4]  = mk(0,0,1,4,0, 0,0,4,0,0,4,0,0,4);
    tbl[5]  = mk(0,0,1,5,0, 0,0,5,0,0,5,0,0,1);
    tbl[6]  = mk(0,1,0,0,0, 0,0,5,0,0,5,0,0,1);
    tbl[7]  = mk(0,0,0,0,1, 1,1,4,0,0,5,0,0,1);
    tbl[8]  = mk(0,0,0,0,1, 1,2,3,0,0,5,0,0,1);
    tbl[9]  = mk(0,0,0,0,1, 1,3,2,0,0,5,0,0,1);
    tbl[10] = mk(0,0,0,0,1, 1,4,1,0,0,5,0,0,1);
    tbl[11] = mk(0,0,0,0,1, 1,5,0,1,0,5,1,0,1);
    tbl[12] = mk(0,0,0,0,1, 0,5,0,1,0,5,0,0,1);
    tbl[13] = mk(0,0,1,7,1, 0,5,0,1,0,5,0,0,1);

    rst = 1'b0; start = 0; done = 0; wr_req = 0; wr_data = '0; rd_req = 0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].st, tbl[i].dn, tbl[i].wr, tbl[i].wd, tbl[i].rd);
      chk($sformatf("row%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
      chk($sformatf("row%0d rd_data", i), 32'(rd_data), 32'(tbl[i].rdat));
      chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("row%0d empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("row%0d full", i), 32'(full), 32'(tbl[i].ful));
      chk($sformatf("row%0d frame_cnt", i), 32'(frame_cnt), 32'(tbl[i].fc));
      chk($sformatf("row%0d frame_done", i), 32'(frame_done), 32'(tbl[i].fd));
      chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(tbl[i].ov));
      chk($sformatf("row%0d checksum", i), 32'(checksum), CK_EN ? 32'(tbl[i].ck) : 0);
    end

    cyc(1,0,0,0,0);
    for (int i = 1; i <= 18; i++) begin
      cyc(0,0,1,21'(i),0);
      if (i == 16) begin
        chk("ovf full@16", 32'(full), 1);
        chk("ovf count@16", 32'(count), 16);
        chk("ovf flag@16", 32'(overflow), 0);
      end
    end
    chk("ovf flag", 32'(overflow), 1);
    chk("ovf frame_cnt", 32'(frame_cnt), 16);
    chk("ovf count", 32'(count), 16);
    chk("ovf checksum", 32'(checksum), CK_EN ? 16 : 0);
    cyc(0,1,0,0,0);
    for (int i = 1; i <= 16; i++) begin
      cyc(0,0,0,0,1);
      chk($sformatf("ovf drain%0d valid", i), 32'(rd_valid), 1);
      chk($sformatf("ovf drain%0d data", i), 32'(rd_data), 32'(i));
    end
    chk("ovf frame_done", 32'(frame_done), 1);
    cyc(0,0,0,0,0);
    chk("ovf frame_done off", 32'(frame_done), 0);

    cyc(1,0,0,0,0);
    for (int i = 1; i <= 16; i++) cyc(0,0,1,21'(100 + i),0);
    cyc(0,0,1,21'd200,1);
    chk("fullrw count", 32'(count), 16);
    chk("fullrw full", 32'(full), 1);
    chk("fullrw rd_valid", 32'(rd_valid), 1);
    chk("fullrw rd_data", 32'(rd_data), 101);
    chk("fullrw overflow", 32'(overflow), 0);
    chk("fullrw frame_cnt", 32'(frame_cnt), 17);
    cyc(0,1,0,0,0);
    for (int i = 2; i <= 17; i++) begin
      cyc(0,0,0,0,1);
      chk($sformatf("fullrw drain%0d data", i), 32'(rd_data), i == 17 ? 200 : 32'(100 + i));
    end
    chk("fullrw frame_done", 32'(frame_done), 1);
    cyc(0,0,0,0,0);

    cyc(1,0,0,0,0);
    cyc(0,0,1,21'd11,0);
    cyc(0,0,1,21'd12,0);
    cyc(0,0,1,21'd13,0);
    chk("pre-reset count", 32'(count), 3);
    #2 rst = 1'b0;
    #1 chk_reset("midreset");
    @(negedge clk);
    rst = 1'b1;
    cyc(1,0,0,0,0);
    cyc(0,0,1,21'h0abcd,0);
    chk("post-reset frame_cnt", 32'(frame_cnt), 1);
    chk("post-reset count", 32'(count), 1);
    cyc(0,1,1,21'h01234,0);
    chk("done+write frame_cnt", 32'(frame_cnt), 2);
    chk("done+write count", 32'(count), 2);
    cyc(0,0,0,0,1);
    chk("post-reset rd1", 32'(rd_data), 32'h0abcd);
    cyc(0,0,0,0,1);
    chk("post-reset rd2", 32'(rd_data), 32'h01234);
    chk("post-reset frame_done", 32'(frame_done), 1);
    cyc(0,0,0,0,0);

    cyc(1,0,0,0,0);
    cyc(0,0,1,21'd1,0);
    for (int k = 2; k <= 40; k++) begin
      cyc(0,0,1,21'(k),1);
      chk($sformatf("wrap%0d valid", k), 32'(rd_valid), 1);
      chk($sformatf("wrap%0d data", k), 32'(rd_data), 32'(k - 1));
      chk($sformatf("wrap%0d count", k), 32'(count), 1);
    end
    cyc(0,1,0,0,1);
    chk("wrap last data", 32'(rd_data), 40);
    chk("wrap frame_cnt", 32'(frame_cnt), 40);
    chk("wrap frame_done", 32'(frame_done), 1);
    chk("wrap checksum", 32'(checksum), CK_EN ? 40 : 0);
    cyc(0,0,0,0,0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/result_collector.md
# result_collector

Write-side sink for the accelerator wrapper. It accepts the wrapper's `wr_req`/`wr_data` write stream into an on-chip FIFO and tracks each start-to-done frame. Stored results are presented to a downstream reader through a request/valid read port. It sits between the accelerator wrapper and whatever consumes its results, such as a host interface or display logic.

## Interface
- `DATA_W`, 21: width of the write and read data; matches the wrapper's `wr_data`.
- `DEPTH`, 16: number of FIFO entries; must be a power of two.
- `ADDR_W`, 4: log2(`DEPTH`).
- `CNT_W`, 8: width of the per-frame write counter.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous reset, active-low (0 = reset).
- `start`  in  1  the same start pulse that is given to the wrapper; opens a frame.
- `done`  in  1  the wrapper's done level; closes a frame.
- `wr_req`  in  1  write strobe from the wrapper; one word per cycle while high.
- `wr_data`  in  `DATA_W`  write word; sampled when `wr_req` = 1.
- `rd_req`  in  1  reader pops one word.
- `rd_data`  out  `DATA_W`  popped word; registered.
- `rd_valid`  out  1  `rd_data` is new this cycle.
- `empty`, `full`  out  1  FIFO status.
- `count`  out  `ADDR_W`+1  FIFO occupancy, range 0..`DEPTH`.
- `frame_cnt`  out  `CNT_W`  words accepted in the current or last frame; saturates at all-ones.
- `frame_done`  out  1  one-cycle pulse when a closed frame has fully drained.
- `overflow`  out  1  sticky flag: a word was dropped in this frame.
- `checksum`  out  `DATA_W`  see Configuration.

## Operation
The frame FSM has three states: IDLE, COLLECT and DRAIN.

- **IDLE**
  - `start` = 1 moves to COLLECT.
  - On that move, `frame_cnt`, `overflow` and `checksum` are cleared.
  - `wr_req` is ignored in IDLE.
- **COLLECT**
  - Writes are accepted.
  - `done` = 1 moves to DRAIN. A write presented in the same cycle as `done` is still accepted.
  - `start` is ignored.
- **DRAIN**
  - `wr_req` is ignored.
  - When `empty` = 1, the FSM moves to IDLE and pulses `frame_done` for one cycle.
  - If the FIFO is already empty on entry, this happens one cycle after entering DRAIN.

Write acceptance:
- `wr_acc` = COLLECT & `wr_req` & (!`full` | `rd_acc`).
- On `wr_acc`, the word is stored at the write pointer, `frame_cnt` increments (saturating), and the checksum updates.
- If COLLECT & `wr_req` & !`wr_acc`, the word is dropped and `overflow` is set. `overflow` holds until the next frame opens.

Read acceptance:
- `rd_acc` = `rd_req` & !`empty`. Reads are allowed in every state.
- On `rd_acc`, `rd_data` is loaded from the read pointer and `rd_valid` = 1 in the next cycle.
- `rd_req` while empty is ignored: `rd_valid` = 0 and `rd_data` holds its value.

Pointers and status:
- Pointers are `ADDR_W` bits and wrap naturally.
- `count` changes by +1 on a write only, -1 on a read only, and 0 when both or neither occur.
- `full` = (`count` == `DEPTH`); `empty` = (`count` == 0). Both are derived from registered `count`.

## Timing
- Reset value of every output is 0, except `empty` = 1. The FSM resets to IDLE and the pointers to 0.
- Reset asserted mid-frame discards FIFO contents and returns to IDLE immediately, without waiting for a clock.
- Read latency is 1 cycle from `rd_req` to `rd_valid`/`rd_data`. Sustained throughput is 1 read per cycle.
- Write latency: an accepted word is visible in `count` next cycle. It can be read no earlier than the cycle after it was written; there is no fall-through.
- Simultaneous write and read when full: both succeed and `count` stays at `DEPTH`.
- Simultaneous write and read when empty: the read is ignored and the write succeeds.
- `start` and `done` in the same cycle while in IDLE: the FSM goes to COLLECT. `done` is re-evaluated next cycle, so with `done` held high the frame closes after 1 cycle.

## Configuration
- `RESULT_COLLECTOR_CHECKSUM_EN` defined:
  - `checksum` = running XOR of every accepted `wr_data` in the frame.
  - It updates in the cycle after each `wr_acc` and clears when a frame opens.
- Undefined: `checksum` is tied to 0 and no checksum register exists.

## Test plan
- **Basic frame:** reset low for 30 ns; `start` pulse; 5 writes 21'h00001..21'h00005; then `done` = 1; then `rd_req` high for 6 cycles.
  - Expect `rd_data` 1..5 on 5 consecutive `rd_valid` cycles, `frame_cnt` = 5, `frame_done` pulses once, `overflow` = 0.
  - With the macro defined, expect `checksum` = 21'h00001.
- **Overflow:** `start`; 18 back-to-back writes with no reads.
  - Expect `full` = 1 after the 16th write, `count` = 16, `overflow` = 1, `frame_cnt` = 16.
  - Draining returns words 1..16 in order.
- **Full with concurrent read:** fill to 16, then a write and `rd_req` in the same cycle.
  - Expect both accepted, `count` stays 16, `overflow` = 0.
- **Ignored events:** `wr_req` in IDLE and `rd_req` while empty.
  - Expect `count` = 0, `rd_valid` = 0, `frame_cnt` unchanged.
- **Reset mid-frame:** reset after 3 writes.
  - Expect all outputs at reset values immediately, with `empty` = 1.
  - A subsequent `start` plus 1 write gives `frame_cnt` = 1.
- **Wrap-around:** 40 writes interleaved with reads, occupancy never above 4.
  - Expect data returned in order and `frame_cnt` = 40.
